// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory byte-write port of the program loader.
// The master modport is the host/memory side; the slave modport is the loader itself.
interface instr_loader_if #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 8
);
    logic               byte_valid;
    logic [D_WIDTH-1:0] byte_data;
    logic               byte_ready;
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/instr_loader.sv
// Program image loader: parses a length-prefixed, XOR-checksummed byte stream and
// writes the payload into instruction memory while holding the CPU.
//
// state  | meaning
// S_IDLE | after reset, waiting for start, CPU not held
// S_LEN  | shifting in the 4 big-endian length bytes
// S_DATA | writing payload bytes to memory
// S_CHK  | waiting for the checksum byte
// S_DONE | image loaded and verified, CPU released
// S_ERR  | image rejected, CPU kept on hold
module instr_loader #(
    parameter int                 A_WIDTH   = 32,
    parameter int                 D_WIDTH   = 8,
    parameter int                 MEM_BYTES = 2048,
    parameter logic [A_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    instr_loader_if.slave bus,
    output logic          cpu_hold_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_LEN = 32'(MEM_BYTES);

    state_t             state_q;
    logic [23:0]        len_q;
    logic [1:0]         len_cnt_q;
    logic [31:0]        rem_q;
    logic [A_WIDTH-1:0] idx_q;
    logic [D_WIDTH-1:0] xor_q;
    logic               byte_ready_q;
    logic               wr_en_q;
    logic [A_WIDTH-1:0] wr_addr_q;
    logic [D_WIDTH-1:0] wr_data_q;
    logic               cpu_hold_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic               xfer;
    logic [31:0]        len_d;

    assign xfer  = bus.byte_valid & byte_ready_q;
    assign len_d = {len_q, bus.byte_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            len_cnt_q    <= '0;
            rem_q        <= '0;
            idx_q        <= '0;
            xor_q        <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q      <= S_LEN;
                        len_q        <= '0;
                        len_cnt_q    <= '0;
                        idx_q        <= '0;
                        xor_q        <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cpu_hold_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len_q     <= len_d[23:0];
                        len_cnt_q <= len_cnt_q + 2'd1;
                        rem_q     <= len_d;
                        if (len_cnt_q == 2'd3) begin
                            // Oversized images are rejected before any byte reaches memory.
                            if (len_d > MAX_LEN) begin
                                state_q      <= S_ERR;
                                error_q      <= 1'b1;
                                busy_q       <= 1'b0;
                                byte_ready_q <= 1'b0;
                            end else if (len_d == 32'd0) begin
                                state_q <= S_CHK;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= BASE_ADDR + idx_q;
                        wr_data_q <= bus.byte_data;
                        idx_q     <= idx_q + 1'b1;
                        xor_q     <= xor_q ^ bus.byte_data;
                        rem_q     <= rem_q - 32'd1;
                        if (rem_q == 32'd1) begin
                            state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        busy_q       <= 1'b0;
                        byte_ready_q <= 1'b0;
                        if (bus.byte_data == xor_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    cpu_hold_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a table of frames with hand-computed results,
// plus directed sequences for oversize, max length, stalls, start-while-busy and reset.
module tb_instr_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic cpu_hold_o, busy_o, done_o, error_o;

    int n_checks = 0;
    int n_fail   = 0;

    instr_loader_if #(.A_WIDTH(32), .D_WIDTH(8)) bus ();

    instr_loader #(.A_WIDTH(32), .D_WIDTH(8), .MEM_BYTES(2048), .BASE_ADDR(32'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bus        (bus),
        .cpu_hold_o (cpu_hold_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] n;
        logic [63:0] pl;
        logic [7:0]  chk;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    // Every write strobe is logged as {addr, data}.
    logic [39:0] wlog[$];
    always @(negedge clk) begin
        if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic [4:0] exp);
        check(name, {bus.byte_ready, busy_o, cpu_hold_o, done_o, error_o}, {59'd0, exp});
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        bit took = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!took && guard < 50) begin
            took = bus.byte_ready;
            @(negedge clk);
            guard++;
        end
        bus.byte_valid = 1'b0;
        if (!took) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_len(input logic [31:0] n, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8], gaps);
    endtask

    task automatic run_frame(input vec_t v, input bit gaps, input bit mid_start);
        logic [63:0] pl;
        pl = v.pl;
        wlog.delete();
        pulse_start();
        check_status("after_start", 5'b11100);
        send_len(v.n, gaps);
        for (int i = 0; i < int'(v.n); i++) begin
            if (mid_start && i == 3) begin
                pulse_start();
                check_status("start_while_busy", 5'b11100);
            end
            send_byte(pl[63-8*i -: 8], gaps);
        end
        send_byte(v.chk, gaps);
        check_status("end_status", {2'b00, ~v.exp_done, v.exp_done, v.exp_err});
        @(negedge clk);
        check("write_count", 64'(wlog.size()), 64'(v.n));
        for (int i = 0; i < wlog.size() && i < int'(v.n); i++)
            check("write_addr_data", 64'(wlog[i]), {24'd0, 32'(i), pl[63-8*i -: 8]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        vecs[0] = '{32'd4, 64'h1305_1000_0000_0000, 8'h06, 1'b1, 1'b0};
        vecs[1] = '{32'd4, 64'h1305_1000_0000_0000, 8'h07, 1'b0, 1'b1};
        vecs[2] = '{32'd0, 64'h0,                   8'h00, 1'b1, 1'b0};
        vecs[3] = '{32'd0, 64'h0,                   8'h01, 1'b0, 1'b1};
        vecs[4] = '{32'd8, 64'h0102_0408_1020_4080, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{32'd1, 64'hA500_0000_0000_0000, 8'hA5, 1'b1, 1'b0};
        vecs[6] = '{32'd3, 64'hFFFF_FF00_0000_0000, 8'hFF, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check_status("reset_status", 5'b00000);
        check("reset_wr", {31'd0, bus.wr_en, bus.wr_addr}, 64'd0);
        rst = 1'b0;

        // Bytes offered in IDLE must not be consumed.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        check_status("idle_no_ready", 5'b00000);
        check("idle_no_write", 64'(wlog.size()), 64'd0);

        for (int k = 0; k < 7; k++) run_frame(vecs[k], 1'b0, 1'b0);

        // Stalls plus a start pulse in the middle of the payload.
        run_frame(vecs[4], 1'b1, 1'b1);

        // Oversize: 2049 bytes.
        wlog.delete();
        pulse_start();
        send_len(32'd2049, 1'b0);
        check_status("oversize_err", 5'b00101);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h11;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        check_status("err_no_ready", 5'b00101);
        check("oversize_no_write", 64'(wlog.size()), 64'd0);

        // Maximum legal length: 2048 bytes of i[7:0]; XOR over 8 full 0..255 runs is 0.
        wlog.delete();
        pulse_start();
        send_len(32'd2048, 1'b0);
        for (int i = 0; i < 2048; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("max_len_done", 5'b00010);
        @(negedge clk);
        check("max_len_count", 64'(wlog.size()), 64'd2048);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {32'(i), 8'(i)}) bad++;
        check("max_len_writes", 64'(bad), 64'd0);
        if (wlog.size() == 2048) check("max_len_last_addr", 64'(wlog[2047][39:8]), 64'd2047);

        // Reset after 2 of 4 payload bytes.
        wlog.delete();
        pulse_start();
        send_len(32'd4, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_status("midload_reset_status", 5'b00000);
        check("midload_reset_wr", {23'd0, bus.wr_en, bus.wr_addr, bus.wr_data}, 64'd0);
        run_frame(vecs[0], 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
